fpsu_ctl_pipe: RTL and testbench

FPSU_CTL_PIPE -- requirements
Module: fpsu_ctl_pipe

---
 rtl/fpsu_pkg.sv | 17 +
 rtl/fpsu_ctl_lane.sv | 72 +++++++
 rtl/fpsu_ctl_pipe.sv | 74 +++++++
 tb/tb_fpsu_ctl_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fpsu_pkg.sv
// rtl/fpsu_pkg.sv - shared defaults and port-slice helpers for the FP control pipe
package fpsu_pkg;

  localparam int NPORT_DEF   = 3;
  localparam int DEPTH_DEF   = 3;
  localparam int OPW_DEF     = 21;
  localparam int ADD_BIT_DEF = 10;
  localparam int RETW_DEF    = 14;

  // Width of each per-port occupancy field; holds counts up to 8.
  localparam int OCCW = 4;

  function automatic int lane_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/fpsu_ctl_lane.sv
// rtl/fpsu_ctl_lane.sv - one issue port's vld/op/xsub shift chain with occupancy count
module fpsu_ctl_lane
  import fpsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_en,
  input  logic [OPW-1:0]  in_op,
  input  logic            in_xsub,
  output logic            out_vld,
  output logic [OPW-1:0]  out_op,
  output logic            out_xsub,
  output logic [OCCW-1:0] occ
);

  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0][OPW-1:0] op_q, op_d;
  logic [DEPTH-1:0]          xsub_q, xsub_d;
  logic [OCCW-1:0]           occ_q, occ_d;

  // op/xsub only move behind a valid entry, so an idle stage keeps its last op.
  always_comb begin
    vld_d  = vld_q;
    op_d   = op_q;
    xsub_d = xsub_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0] = in_en;
      if (in_en) begin
        op_d[0]   = in_op;
        xsub_d[0] = in_xsub;
      end
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          op_d[k]   = op_q[k-1];
          xsub_d[k] = xsub_q[k-1];
        end
      end
    end
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCCW'(vld_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      op_q   <= '0;
      xsub_q <= '0;
      occ_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      op_q   <= op_d;
      xsub_q <= xsub_d;
      occ_q  <= occ_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_op   = op_q[DEPTH-1];
  assign out_xsub = xsub_q[DEPTH-1];
  assign occ      = occ_q;

endmodule

// File: rtl/fpsu_ctl_pipe.sv
// rtl/fpsu_ctl_pipe.sv - per-port FP control pipeline with late-add select and retire merge
module fpsu_ctl_pipe
  import fpsu_pkg::*;
#(
  parameter int NPORT   = NPORT_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ADD_BIT = ADD_BIT_DEF,
  parameter int RETW    = RETW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      in_en,
  input  logic [NPORT*OPW-1:0]  in_op,
  input  logic [NPORT-1:0]      in_xsub,
  input  logic                  stall,
  input  logic [NPORT-1:0]      flush,
  output logic [NPORT-1:0]      late_add,
  output logic [NPORT*OPW-1:0]  out_op,
  output logic [NPORT-1:0]      out_vld,
  output logic [NPORT*OCCW-1:0] occ,
  input  logic [NPORT*RETW-1:0] retH,
  input  logic [NPORT*RETW-1:0] retL,
  input  logic [NPORT-1:0]      ret_enH,
  input  logic [NPORT-1:0]      ret_enL,
  output logic [NPORT*RETW-1:0] ret,
  output logic [NPORT-1:0]      ret_en,
  input  logic                  err_clr,
  output logic [NPORT-1:0]      ret_err
);

  logic [NPORT-1:0] xsub_last;
  logic [NPORT-1:0] ret_err_q, ret_err_d;

  for (genvar p = 0; p < NPORT; p++) begin : g_lane
    fpsu_ctl_lane #(
      .DEPTH (DEPTH),
      .OPW   (OPW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .flush    (flush[p]),
      .in_en    (in_en[p]),
      .in_op    (in_op[lane_lo(p, OPW) +: OPW]),
      .in_xsub  (in_xsub[p]),
      .out_vld  (out_vld[p]),
      .out_op   (out_op[lane_lo(p, OPW) +: OPW]),
      .out_xsub (xsub_last[p]),
      .occ      (occ[lane_lo(p, OCCW) +: OCCW])
    );

    assign late_add[p] = out_vld[p] & ~xsub_last[p] & out_op[lane_lo(p, OPW) + ADD_BIT];
  end

  assign ret    = retH | retL;
  assign ret_en = ret_enH | ret_enL;

  // A new collision outranks a simultaneous clear.
  always_comb begin
    ret_err_d = (ret_err_q & {NPORT{~err_clr}}) | (ret_enH & ret_enL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_err_q <= '0;
    end else begin
      ret_err_q <= ret_err_d;
    end
  end

  assign ret_err = ret_err_q;

endmodule

// File: tb/tb_fpsu_ctl_pipe.sv
// tb/tb_fpsu_ctl_pipe.sv - directed self-checking bench for fpsu_ctl_pipe
module tb_fpsu_ctl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  a_in_en, a_in_xsub, a_flush, a_late_add, a_out_vld;
  logic [62:0] a_in_op, a_out_op;
  logic        a_stall, a_err_clr;
  logic [11:0] a_occ;
  logic [41:0] a_retH, a_retL, a_ret;
  logic [2:0]  a_ret_enH, a_ret_enL, a_ret_en, a_ret_err;

  fpsu_ctl_pipe u_dut_a (
    .clk(clk), .rst(rst),
    .in_en(a_in_en), .in_op(a_in_op), .in_xsub(a_in_xsub),
    .stall(a_stall), .flush(a_flush),
    .late_add(a_late_add), .out_op(a_out_op), .out_vld(a_out_vld), .occ(a_occ),
    .retH(a_retH), .retL(a_retL), .ret_enH(a_ret_enH), .ret_enL(a_ret_enL),
    .ret(a_ret), .ret_en(a_ret_en), .err_clr(a_err_clr), .ret_err(a_ret_err)
  );

  logic [3:0]  b_in_en, b_in_xsub, b_flush, b_late_add, b_out_vld;
  logic [83:0] b_in_op, b_out_op;
  logic        b_stall, b_err_clr;
  logic [15:0] b_occ;
  logic [55:0] b_retH, b_retL, b_ret;
  logic [3:0]  b_ret_enH, b_ret_enL, b_ret_en, b_ret_err;

  fpsu_ctl_pipe #(.NPORT(4), .DEPTH(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_en(b_in_en), .in_op(b_in_op), .in_xsub(b_in_xsub),
    .stall(b_stall), .flush(b_flush),
    .late_add(b_late_add), .out_op(b_out_op), .out_vld(b_out_vld), .occ(b_occ),
    .retH(b_retH), .retL(b_retL), .ret_enH(b_ret_enH), .ret_enL(b_ret_enL),
    .ret(b_ret), .ret_en(b_ret_en), .err_clr(b_err_clr), .ret_err(b_ret_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_in_en = '0; a_in_op = '0; a_in_xsub = '0; a_stall = 1'b0; a_flush = '0;
    a_retH = '0; a_retL = '0; a_ret_enH = '0; a_ret_enL = '0; a_err_clr = 1'b0;
    b_in_en = '0; b_in_op = '0; b_in_xsub = '0; b_stall = 1'b0; b_flush = '0;
    b_retH = '0; b_retL = '0; b_ret_enH = '0; b_ret_enL = '0; b_err_clr = 1'b0;
    tick(); tick();
    chk("rst_out_vld", 64'(a_out_vld), 64'h0);
    chk("rst_late_add", 64'(a_late_add), 64'h0);
    chk("rst_occ", 64'(a_occ), 64'h0);
    chk("rst_out_op", 64'(a_out_op), 64'h0);
    chk("rst_ret_err", 64'(a_ret_err), 64'h0);
    rst = 1'b1;

    // add op, xsub=0: visible after the third edge for one cycle
    a_in_en = 3'b001; a_in_op = 63'h400; a_in_xsub = 3'b000;
    tick();
    a_in_en = '0; a_in_op = '0;
    chk("s1_e1_vld", 64'(a_out_vld), 64'h0);
    chk("s1_e1_occ", 64'(a_occ), 64'h001);
    tick();
    chk("s1_e2_vld", 64'(a_out_vld), 64'h0);
    chk("s1_e2_late", 64'(a_late_add), 64'h0);
    tick();
    chk("s1_e3_vld", 64'(a_out_vld), 64'h1);
    chk("s1_e3_late", 64'(a_late_add), 64'h1);
    chk("s1_e3_op", 64'(a_out_op), 64'h400);
    tick();
    chk("s1_e4_vld", 64'(a_out_vld), 64'h0);
    chk("s1_e4_late", 64'(a_late_add), 64'h0);
    chk("s1_e4_op_hold", 64'(a_out_op), 64'h400);
    chk("s1_e4_occ", 64'(a_occ), 64'h0);

    // subtract-qualified add op never selects late add
    a_in_en = 3'b001; a_in_op = 63'h401; a_in_xsub = 3'b001;
    tick();
    a_in_en = '0; a_in_op = '0; a_in_xsub = '0;
    tick(); tick();
    chk("s2_e3_vld", 64'(a_out_vld), 64'h1);
    chk("s2_e3_late", 64'(a_late_add), 64'h0);
    chk("s2_e3_op", 64'(a_out_op), 64'h401);
    tick();

    // two stall cycles push the output from edge 3 to edge 5
    a_in_en = 3'b001; a_in_op = 63'h400;
    tick();
    a_in_en = '0; a_in_op = '0; a_stall = 1'b1;
    tick();
    chk("s3_st1_occ", 64'(a_occ), 64'h001);
    chk("s3_st1_vld", 64'(a_out_vld), 64'h0);
    tick();
    chk("s3_st2_occ", 64'(a_occ), 64'h001);
    a_stall = 1'b0;
    tick();
    chk("s3_e4_vld", 64'(a_out_vld), 64'h0);
    tick();
    chk("s3_e5_vld", 64'(a_out_vld), 64'h1);
    chk("s3_e5_late", 64'(a_late_add), 64'h1);
    tick();

    // port1 back-to-back ops flushed on the third; port0 rides alongside
    a_in_en = 3'b011; a_in_op = {21'h0, 21'h402, 21'h400};
    tick();
    a_in_en = 3'b010; a_in_op = {21'h0, 21'h403, 21'h0};
    tick();
    a_in_op = {21'h0, 21'h404, 21'h0}; a_flush = 3'b010;
    tick();
    a_in_en = '0; a_in_op = '0; a_flush = '0;
    chk("s4_flush_occ", 64'(a_occ), 64'h001);
    chk("s4_flush_vld", 64'(a_out_vld), 64'h1);
    chk("s4_flush_late", 64'(a_late_add), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_post_vld", 64'(a_out_vld), 64'h0);
    end
    chk("s4_p1_op", 64'(a_out_op[41:21]), 64'h0);

    // half collision on port2
    a_ret_enH = 3'b100; a_ret_enL = 3'b100;
    a_retH = 42'h0010 << 28; a_retL = 42'h0001 << 28;
    #1;
    chk("s5_ret", 64'(a_ret), 64'h0011 << 28);
    chk("s5_ret_en", 64'(a_ret_en), 64'h4);
    chk("s5_err_pre", 64'(a_ret_err), 64'h0);
    tick();
    chk("s5_err_set", 64'(a_ret_err), 64'h4);
    a_ret_enH = '0; a_ret_enL = '0; a_retH = '0; a_retL = '0;
    tick();
    chk("s5_err_hold", 64'(a_ret_err), 64'h4);
    a_err_clr = 1'b1;
    tick();
    chk("s5_err_clr", 64'(a_ret_err), 64'h0);
    a_ret_enH = 3'b001; a_ret_enL = 3'b001;
    tick();
    chk("s5_set_wins", 64'(a_ret_err), 64'h1);
    a_ret_enH = '0; a_ret_enL = '0;
    tick();
    a_err_clr = 1'b0;
    chk("s5_clr_again", 64'(a_ret_err), 64'h0);

    // async reset with two ops in flight
    a_in_en = 3'b001; a_in_op = 63'h401; a_ret_enH = 3'b010; a_ret_enL = 3'b010;
    tick();
    a_ret_enH = '0; a_ret_enL = '0;
    tick();
    a_in_en = '0; a_in_op = '0;
    chk("s6_pre_occ", 64'(a_occ), 64'h002);
    chk("s6_pre_err", 64'(a_ret_err), 64'h2);
    #2 rst = 1'b0;
    #1;
    chk("s6_rst_vld", 64'(a_out_vld), 64'h0);
    chk("s6_rst_occ", 64'(a_occ), 64'h0);
    chk("s6_rst_op", 64'(a_out_op), 64'h0);
    chk("s6_rst_late", 64'(a_late_add), 64'h0);
    chk("s6_rst_err", 64'(a_ret_err), 64'h0);
    tick();
    rst = 1'b1;

    // NPORT=4, DEPTH=1 instance: one-edge latency
    b_in_en = 4'b0001; b_in_op = 84'h400;
    tick();
    b_in_en = '0; b_in_op = '0;
    chk("b_e1_vld", 64'(b_out_vld), 64'h1);
    chk("b_e1_late", 64'(b_late_add), 64'h1);
    chk("b_e1_occ", 64'(b_occ), 64'h0001);
    tick();
    chk("b_e2_vld", 64'(b_out_vld), 64'h0);
    chk("b_e2_op", 64'(b_out_op[20:0]), 64'h400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
